// File: rtl/vga_sync_rx.sv
// vga_sync_rx: VGA receive-side monitor that rebuilds the frame position from HSync/VSync,
// checks line and frame timing against the configured mode and reports lock.
//   i_Clk, i_Reset          pixel clock, asynchronous active-high reset
//   i_HSync, i_VSync        active-low syncs from the VGA output path
//   i_Red, i_Grn, i_Blu     3-bit pixel colour
//   o_Col, o_Row            visible-pixel position, 0 outside the active window
//   o_Active                visible pixel while locked
//   o_Red, o_Grn, o_Blu     colour aligned with o_Col/o_Row
//   o_Frame_Start           one-cycle pulse on each VSync falling edge
//   o_Locked                lock status
//   o_Timing_Err            one-cycle pulse per detected timing error
//   o_Err_Count             saturating error count since reset
module vga_sync_rx #(
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int H_ACTIVE    = 640,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_HSync,
   input  logic       i_VSync,
   input  logic [2:0] i_Red,
   input  logic [2:0] i_Grn,
   input  logic [2:0] i_Blu,
   output logic [9:0] o_Col,
   output logic [9:0] o_Row,
   output logic       o_Active,
   output logic [2:0] o_Red,
   output logic [2:0] o_Grn,
   output logic [2:0] o_Blu,
   output logic       o_Frame_Start,
   output logic       o_Locked,
   output logic       o_Timing_Err,
   output logic [7:0] o_Err_Count
);
   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_RISE = 10'(H_SYNC);
   localparam logic [9:0] H_BEG  = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_END  = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] V_BEG  = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_END  = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [9:0] C_MAX  = 10'h3ff;
   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam logic [GW-1:0] G_LOCK = GW'(LOCK_FRAMES);
   state_t state, state_n;
   logic [GW-1:0] good, good_n;
   logic hs1, vs1, hs2, vs2;
   logic [2:0] red1, grn1, blu1;
   logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
   logic first_h, frame_err;
   logic hs_fall, hs_rise, vs_fall, err, win;
   always_comb begin
      hs_fall = hs2 & ~hs1;
      hs_rise = ~hs2 & hs1;
      vs_fall = vs2 & ~vs1;
      h_nxt   = hs_fall ? 10'd0 : (h_cnt == C_MAX) ? h_cnt : h_cnt + 10'd1;
      v_nxt   = vs_fall ? 10'd0 : !hs_fall ? v_cnt : (v_cnt == C_MAX) ? v_cnt : v_cnt + 10'd1;
      // Missing HSync is flagged on the transition into saturation, so it fires once per stall.
      err     = (state != SEARCH) &&
                ((hs_fall && !first_h && h_cnt != H_LAST) ||
                 (hs_rise && h_nxt != H_RISE) ||
                 (vs_fall && v_cnt != V_LAST) ||
                 (h_nxt == C_MAX && h_cnt != C_MAX));
      win     = h_nxt >= H_BEG && h_nxt < H_END && v_nxt >= V_BEG && v_nxt < V_END;
      state_n = state;
      good_n  = good;
      case (state)
         SEARCH: begin
            if (vs_fall) begin
               state_n = ACQUIRE;
               good_n  = '0;
            end
         end
         ACQUIRE: begin
            if (err) good_n = '0;
            else if (vs_fall && !frame_err) begin
               good_n  = good + 1'b1;
               state_n = (good_n == G_LOCK) ? LOCKED : ACQUIRE;
            end
         end
         LOCKED:  state_n = err ? SEARCH : LOCKED;
         default: state_n = SEARCH;
      endcase
   end
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         {hs1, vs1, hs2, vs2} <= 4'hf;
         {red1, grn1, blu1}   <= '0;
         state         <= SEARCH;
         good          <= '0;
         h_cnt         <= '0;
         v_cnt         <= '0;
         first_h       <= 1'b1;
         frame_err     <= 1'b0;
         o_Col         <= '0;
         o_Row         <= '0;
         o_Active      <= 1'b0;
         o_Red         <= '0;
         o_Grn         <= '0;
         o_Blu         <= '0;
         o_Frame_Start <= 1'b0;
         o_Locked      <= 1'b0;
         o_Timing_Err  <= 1'b0;
         o_Err_Count   <= '0;
      end else begin
         {hs1, vs1, hs2, vs2} <= {i_HSync, i_VSync, hs1, vs1};
         {red1, grn1, blu1}   <= {i_Red, i_Grn, i_Blu};
         state         <= state_n;
         good          <= good_n;
         h_cnt         <= h_nxt;
         v_cnt         <= v_nxt;
         // The first line after leaving SEARCH may start from an unaligned count.
         first_h       <= (state == SEARCH) ? 1'b1 : hs_fall ? 1'b0 : first_h;
         frame_err     <= vs_fall ? 1'b0 : frame_err | err;
         o_Col         <= win ? h_nxt - H_BEG : 10'd0;
         o_Row         <= win ? v_nxt - V_BEG : 10'd0;
         o_Active      <= win && state_n == LOCKED;
         o_Red         <= win ? red1 : 3'd0;
         o_Grn         <= win ? grn1 : 3'd0;
         o_Blu         <= win ? blu1 : 3'd0;
         o_Frame_Start <= vs_fall;
         o_Locked      <= state_n == LOCKED;
         o_Timing_Err  <= err;
         o_Err_Count   <= (err && o_Err_Count != 8'hff) ? o_Err_Count + 8'd1 : o_Err_Count;
      end
   end
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: scoreboard bench for vga_sync_rx on a scaled-down video mode.
module tb_vga_sync_rx;
   localparam int HT = 64, HSY = 8, HBP = 8, HA = 40;
   localparam int VT = 20, VSY = 2, VBP = 3, VA = 12;
   localparam int HS0 = HSY + HBP, VS0 = VSY + VBP;
   typedef struct {
      int          due;
      logic [40:0] e;
   } ent_t;
   logic clk = 1'b0;
   logic i_Reset, i_HSync, i_VSync;
   logic [2:0] i_Red, i_Grn, i_Blu;
   logic [9:0] o_Col, o_Row;
   logic o_Active, o_Frame_Start, o_Locked, o_Timing_Err;
   logic [2:0] o_Red, o_Grn, o_Blu;
   logic [7:0] o_Err_Count;
   logic [40:0] obs;
   int cyc = 0;
   int n_run = 0, n_fail = 0;
   ent_t q[$];
   int m_h, m_v;
   logic m_hs, m_vs, lk, te;
   logic [7:0] cnt;
   vga_sync_rx #(
      .H_TOTAL(HT), .H_SYNC(HSY), .H_BP(HBP), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_SYNC(VSY), .V_BP(VBP), .V_ACTIVE(VA), .LOCK_FRAMES(2)
   ) dut (
      .i_Clk(clk), .i_Reset(i_Reset), .i_HSync(i_HSync), .i_VSync(i_VSync),
      .i_Red(i_Red), .i_Grn(i_Grn), .i_Blu(i_Blu),
      .o_Col(o_Col), .o_Row(o_Row), .o_Active(o_Active),
      .o_Red(o_Red), .o_Grn(o_Grn), .o_Blu(o_Blu),
      .o_Frame_Start(o_Frame_Start), .o_Locked(o_Locked),
      .o_Timing_Err(o_Timing_Err), .o_Err_Count(o_Err_Count)
   );
   assign obs = {o_Active, o_Col, o_Row, o_Red, o_Grn, o_Blu,
                 o_Frame_Start, o_Locked, o_Timing_Err, o_Err_Count};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [40:0] got, input logic [40:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask
   task automatic mreset();
      m_h  = 0;
      m_v  = 0;
      m_hs = 1'b1;
      m_vs = 1'b1;
      lk   = 1'b0;
      te   = 1'b0;
      cnt  = 8'd0;
   endtask
   task automatic pop_due();
      ent_t ent;
      while (q.size() > 0 && q[0].due <= cyc) begin
         ent = q.pop_front();
         chk("px", obs, ent.e);
      end
   endtask
   // Drive one pixel, push what the DUT must show for it two clocks later, advance a clock.
   task automatic px(input logic hs, input logic vs, input logic [2:0] r, g, b);
      logic hf, vf, win;
      i_HSync = hs;
      i_VSync = vs;
      i_Red   = r;
      i_Grn   = g;
      i_Blu   = b;
      hf  = m_hs & ~hs;
      vf  = m_vs & ~vs;
      m_h = hf ? 0 : (m_h == 1023) ? 1023 : m_h + 1;
      m_v = vf ? 0 : hf ? m_v + 1 : m_v;
      m_hs = hs;
      m_vs = vs;
      win = m_h >= HS0 && m_h < HS0 + HA && m_v >= VS0 && m_v < VS0 + VA;
      q.push_back('{due: cyc + 2,
                    e: {win & lk, win ? 10'(m_h - HS0) : 10'd0, win ? 10'(m_v - VS0) : 10'd0,
                        win ? {r, g, b} : 9'd0, vf, lk, te, cnt}});
      te = 1'b0;
      @(negedge clk);
      pop_due();
   endtask
   // One frame. lock_ev: lock expected on the opening VSync fall. sl: line stretched by one
   // clock (error on the next line's HSync fall). hl: line with HSync held high for 1000 clocks.
   // rl: line where reset is asserted mid-frame.
   task automatic frame(input bit lock_ev, input int sl, input int hl, input int rl);
      int len;
      logic [2:0] r, g, b;
      for (int vl = 0; vl < VT; vl++) begin
         len = (vl == sl) ? HT + 1 : (vl == hl) ? 1000 : HT;
         for (int p = 0; p < len; p++) begin
            if (vl == rl && p == 20) begin
               #2 i_Reset = 1'b1;
               #1 chk("arst", obs, 41'd0);
               q.delete();
               i_HSync = 1'b1;
               i_VSync = 1'b1;
               repeat (2) @(negedge clk);
               i_Reset = 1'b0;
               mreset();
               chk("rst", obs, 41'd0);
               return;
            end
            if (p == 0 && vl == 0 && lock_ev) lk = 1'b1;
            if ((p == 0 && sl >= 0 && vl == sl + 1) || (vl == hl && p == 1023 - HT)) begin
               lk  = 1'b0;
               te  = 1'b1;
               cnt = cnt + 8'd1;
            end
            {r, g, b} = (vl == 15 && p == 36) ? 9'b101_010_111 : 9'($urandom);
            px(vl == hl || p >= HSY, vl >= VSY, r, g, b);
         end
      end
   endtask
   initial begin
      i_Reset = 1'b1;
      i_HSync = 1'b1;
      i_VSync = 1'b1;
      {i_Red, i_Grn, i_Blu} = '0;
      mreset();
      repeat (3) @(negedge clk);
      chk("rst", obs, 41'd0);
      i_Reset = 1'b0;
      frame(1'b0, -1, -1, -1);
      frame(1'b0, -1, -1, -1);
      frame(1'b1, -1, -1, -1);
      frame(1'b0, -1, -1, -1);
      frame(1'b0, 5, -1, -1);
      frame(1'b0, -1, -1, -1);
      frame(1'b0, -1, -1, -1);
      frame(1'b1, -1, -1, -1);
      frame(1'b0, -1, 10, -1);
      frame(1'b0, -1, -1, -1);
      frame(1'b0, -1, -1, -1);
      frame(1'b1, -1, -1, -1);
      frame(1'b0, -1, -1, 8);
      frame(1'b0, -1, -1, -1);
      frame(1'b0, -1, -1, -1);
      frame(1'b1, -1, -1, -1);
      frame(1'b0, -1, -1, -1);
      repeat (2) @(negedge clk);
      pop_due();
      chk("drain", 41'(q.size()), 41'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
